// File: rtl/rv_predecode_q_pkg.sv
// Shared RV32I predecode definitions: major opcodes (ir[6:2]), FUNC_ADD,
// immediate-select codes and the opcode legality check.
// Latency: n/a (constants and a combinational helper). Backpressure: n/a.
package rv_predecode_q_pkg;

    // Major opcodes, ir[6:2]
    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_FENCE  = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    localparam logic [2:0] FUNC_ADD = 3'b000;

    // Immediate format of x_imm_o
    localparam logic [2:0] IMM_SEL_NONE = 3'd0;
    localparam logic [2:0] IMM_SEL_I    = 3'd1;
    localparam logic [2:0] IMM_SEL_S    = 3'd2;
    localparam logic [2:0] IMM_SEL_B    = 3'd3;
    localparam logic [2:0] IMM_SEL_U    = 3'd4;
    localparam logic [2:0] IMM_SEL_J    = 3'd5;

    // 1 when the word is not a supported 32-bit RV32I instruction.
    function automatic logic opc_illegal(input logic [31:0] ir);
        logic known;
        case (ir[6:2])
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
            OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_FENCE, OPC_SYSTEM: known = 1'b1;
            default: known = 1'b0;
        endcase
        return !known || (ir[1:0] != 2'b11);
    endfunction

endpackage

// File: rtl/rv_predecode_fields.sv
// Splits an instruction word into execute fields and selects its immediate.
// Latency: purely combinational. Backpressure: none.
// Ports: ir (bits 31:2; the length bits are irrelevant here) -> rs1, rs2, rd,
//        shamt, opcode, fun, sign, imm, imm_sel.
module rv_predecode_fields
    import rv_predecode_q_pkg::*;
(
    input  logic [31:2] ir,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [4:0]  opcode,
    output logic [2:0]  fun,
    output logic        sign,
    output logic [31:0] imm,
    output logic [2:0]  imm_sel
);

    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign rd     = ir[11:7];
    assign shamt  = ir[24:20];
    assign opcode = ir[6:2];
    assign sign   = ir[30];

    always_comb begin
        imm_sel = IMM_SEL_NONE;
        fun     = ir[14:12];
        case (ir[6:2])
            OPC_OP_IMM, OPC_LOAD: imm_sel = IMM_SEL_I;
            OPC_JALR: begin
                imm_sel = IMM_SEL_I;
                fun     = FUNC_ADD;   // link address = pc + 4
            end
            OPC_STORE:  imm_sel = IMM_SEL_S;
            OPC_BRANCH: imm_sel = IMM_SEL_B;
            OPC_LUI, OPC_AUIPC: begin
                imm_sel = IMM_SEL_U;
                fun     = FUNC_ADD;   // LUI adds to x0, AUIPC adds to pc
            end
            OPC_JAL: begin
                imm_sel = IMM_SEL_J;
                fun     = FUNC_ADD;
            end
            default: ;
        endcase
    end

    always_comb begin
        imm = '0;
        case (imm_sel)
            IMM_SEL_I: imm = {{20{ir[31]}}, ir[31:20]};
            IMM_SEL_S: imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            IMM_SEL_B: imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            IMM_SEL_U: imm = {ir[31:12], 12'h000};
            IMM_SEL_J: imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default:   imm = '0;
        endcase
    end

endmodule

// File: rtl/rv_predecode_q.sv
// Predecode instruction queue between fetch and execute: DEPTH {pc, ir} entries,
// head presented with fields split; RF read addresses issued one cycle ahead.
// Latency: 1 cycle push-to-head. Backpressure: f_ready_o = !full, registered
// only (no path from x_ready_i); x_kill_i flushes everything.
// Optional: define URV_PREDECODE_ILLEGAL_EN to store a per-entry illegal bit
// decoded at push time; otherwise x_illegal_o is tied low.
module rv_predecode_q
    import rv_predecode_q_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PC_W  = 32
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            f_valid_i,
    output logic            f_ready_o,
    input  logic [PC_W-1:0] f_pc_i,
    input  logic [31:0]     f_ir_i,
    input  logic            x_kill_i,
    output logic            x_valid_o,
    input  logic            x_ready_i,
    output logic [PC_W-1:0] x_pc_o,
    output logic [4:0]      x_rs1_o,
    output logic [4:0]      x_rs2_o,
    output logic [4:0]      x_rd_o,
    output logic [4:0]      x_shamt_o,
    output logic [4:0]      x_opcode_o,
    output logic [2:0]      x_fun_o,
    output logic            x_shifter_sign_o,
    output logic [31:0]     x_imm_o,
    output logic [2:0]      x_imm_sel_o,
    output logic            x_illegal_o,
    output logic [4:0]      rf_rs1_o,
    output logic [4:0]      rf_rs2_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [PC_W-1:0]  mem_pc [DEPTH];
    logic [31:2]      mem_ir [DEPTH];
    logic [PTR_W-1:0] rd_ptr, wr_ptr;
    logic [PTR_W:0]   count;
    logic             push, pop;

    assign f_ready_o = (count != FULL_CNT);
    assign x_valid_o = (count != '0);
    assign push      = f_valid_i && f_ready_o;
    assign pop       = x_valid_o && x_ready_i;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (x_kill_i) begin
            count  <= '0;
            rd_ptr <= wr_ptr;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    // Entry storage is deliberately unreset.
    always_ff @(posedge clk_i) begin
        if (push && !x_kill_i) begin
            mem_pc[wr_ptr] <= f_pc_i;
            mem_ir[wr_ptr] <= f_ir_i[31:2];
        end
    end

    assign x_pc_o = mem_pc[rd_ptr];

    rv_predecode_fields u_fields (
        .ir      (mem_ir[rd_ptr]),
        .rs1     (x_rs1_o),
        .rs2     (x_rs2_o),
        .rd      (x_rd_o),
        .shamt   (x_shamt_o),
        .opcode  (x_opcode_o),
        .fun     (x_fun_o),
        .sign    (x_shifter_sign_o),
        .imm     (x_imm_o),
        .imm_sel (x_imm_sel_o)
    );

    // RF lookahead: the entry that will sit at the head next cycle. If nothing
    // remains after this cycle's pop, the only candidate is the word being pushed.
    logic [PTR_W-1:0] la_ptr;
    logic [PTR_W:0]   la_left;
    logic [31:2]      la_ir;

    assign la_ptr  = rd_ptr + PTR_W'(pop);
    assign la_left = count - (PTR_W+1)'(pop);

    always_comb begin
        la_ir = f_ir_i[31:2];
        if (!x_kill_i && la_left != '0) la_ir = mem_ir[la_ptr];
    end

    assign rf_rs1_o = la_ir[19:15];
    assign rf_rs2_o = la_ir[24:20];

`ifdef URV_PREDECODE_ILLEGAL_EN
    logic mem_ill [DEPTH];

    always_ff @(posedge clk_i) begin
        if (push && !x_kill_i) mem_ill[wr_ptr] <= opc_illegal(f_ir_i);
    end

    assign x_illegal_o = mem_ill[rd_ptr];
`else
    // Length bits only matter to the illegal check.
    logic unused_ir_len;
    assign unused_ir_len = ^f_ir_i[1:0];
    assign x_illegal_o   = 1'b0;
`endif

endmodule

// File: tb/tb_rv_predecode_q.sv
// Bench for rv_predecode_q: queue-based reference model checked every cycle
// plus directed vectors with literal expectations.
module tb_rv_predecode_q;
    import rv_predecode_q_pkg::IMM_SEL_NONE, rv_predecode_q_pkg::IMM_SEL_I,
           rv_predecode_q_pkg::IMM_SEL_S, rv_predecode_q_pkg::IMM_SEL_B,
           rv_predecode_q_pkg::IMM_SEL_U, rv_predecode_q_pkg::IMM_SEL_J,
           rv_predecode_q_pkg::FUNC_ADD;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;

    logic clk = 1'b0;
    logic rst_n, f_valid, f_ready, x_kill, x_valid, x_ready;
    logic [31:0] f_pc, f_ir, x_pc, x_imm;
    logic [4:0]  x_rs1, x_rs2, x_rd, x_shamt, x_opcode, rf_rs1, rf_rs2;
    logic [2:0]  x_fun, x_imm_sel;
    logic        x_sign, x_illegal;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    rv_predecode_q #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .f_valid_i(f_valid), .f_ready_o(f_ready), .f_pc_i(f_pc), .f_ir_i(f_ir),
        .x_kill_i(x_kill), .x_valid_o(x_valid), .x_ready_i(x_ready),
        .x_pc_o(x_pc), .x_rs1_o(x_rs1), .x_rs2_o(x_rs2), .x_rd_o(x_rd),
        .x_shamt_o(x_shamt), .x_opcode_o(x_opcode), .x_fun_o(x_fun),
        .x_shifter_sign_o(x_sign), .x_imm_o(x_imm), .x_imm_sel_o(x_imm_sel),
        .x_illegal_o(x_illegal), .rf_rs1_o(rf_rs1), .rf_rs2_o(rf_rs2)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [31:0] pc; logic [31:0] ir; } entry_t;
    entry_t q[$];

    // Decode from the instruction-set definition of each format.
    function automatic void decode(input logic [31:0] ir, output logic [31:0] imm,
                                   output logic [2:0] sel, output logic [2:0] fun,
                                   output logic ill);
        logic signed [11:0] i12, s12, b12;
        logic signed [19:0] j20;
        logic signed [31:0] w;
        i12 = ir[31:20];
        s12 = {ir[31:25], ir[11:7]};
        b12 = {ir[31], ir[7], ir[30:25], ir[11:8]};
        j20 = {ir[31], ir[19:12], ir[20], ir[30:21]};
        imm = 0; sel = IMM_SEL_NONE; fun = ir[14:12]; ill = 1'b0;
        case (ir[6:0] | 7'b0000011)
            7'h13, 7'h03: begin w = i12; imm = w; sel = IMM_SEL_I; end
            7'h67: begin w = i12; imm = w; sel = IMM_SEL_I; fun = FUNC_ADD; end
            7'h23: begin w = s12; imm = w; sel = IMM_SEL_S; end
            7'h63: begin w = b12; imm = w * 2; sel = IMM_SEL_B; end
            7'h37, 7'h17: begin imm = ir & 32'hFFFF_F000; sel = IMM_SEL_U; fun = FUNC_ADD; end
            7'h6F: begin w = j20; imm = w * 2; sel = IMM_SEL_J; fun = FUNC_ADD; end
            7'h33, 7'h0F, 7'h73: ;
            default: ill = 1'b1;
        endcase
        if (ir[1:0] != 2'b11) ill = 1'b1;
`ifndef URV_PREDECODE_ILLEGAL_EN
        ill = 1'b0;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) q.delete();
        else begin
            bit m_push, m_pop;
            m_push = f_valid && (q.size() < DEPTH);
            m_pop  = x_ready && (q.size() > 0);
            if (x_kill) q.delete();
            else begin
                if (m_pop) void'(q.pop_front());
                if (m_push) q.push_back('{pc: f_pc, ir: f_ir});
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] e_imm;
        logic [2:0]  e_sel, e_fun;
        logic        e_ill;
        int          pop_n, left;
        chk("model_x_valid", x_valid, (q.size() != 0));
        chk("model_f_ready", f_ready, (q.size() < DEPTH));
        if (q.size() != 0) begin
            decode(q[0].ir, e_imm, e_sel, e_fun, e_ill);
            chk("model_pc", x_pc, q[0].pc);
            chk("model_rs1", x_rs1, q[0].ir[19:15]);
            chk("model_rs2", x_rs2, q[0].ir[24:20]);
            chk("model_rd", x_rd, q[0].ir[11:7]);
            chk("model_shamt", x_shamt, q[0].ir[24:20]);
            chk("model_opcode", x_opcode, q[0].ir[6:2]);
            chk("model_sign", x_sign, q[0].ir[30]);
            chk("model_fun", x_fun, e_fun);
            chk("model_imm", x_imm, e_imm);
            chk("model_imm_sel", x_imm_sel, e_sel);
            chk("model_illegal", x_illegal, e_ill);
        end
        if (rst_n && !x_kill) begin
            pop_n = (x_ready && q.size() > 0) ? 1 : 0;
            left  = q.size() - pop_n;
            if (left > 0) begin
                chk("model_rf_rs1", rf_rs1, q[pop_n].ir[19:15]);
                chk("model_rf_rs2", rf_rs2, q[pop_n].ir[24:20]);
            end else if (f_valid && q.size() < DEPTH) begin
                chk("model_rf_rs1_byp", rf_rs1, f_ir[19:15]);
                chk("model_rf_rs2_byp", rf_rs2, f_ir[24:20]);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drv(input logic v, input logic [31:0] pc, input logic [31:0] ir,
                       input logic rdy, input logic kl);
        f_valid = v; f_pc = pc; f_ir = ir; x_ready = rdy; x_kill = kl;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        drv(0, 0, 0, 1, 0);
        repeat (DEPTH) cyc();
        drv(0, 0, 0, 0, 0);
    endtask

    logic [31:0] t_ir  [6] = '{32'h123452B7, 32'hFE208CE3, 32'h002081B3,
                               32'h0000007F, 32'h00001517, 32'hFF012283};
    logic [31:0] t_imm [6] = '{32'h12345000, 32'hFFFFFFF8, 32'h0, 32'h0,
                               32'h00001000, 32'hFFFFFFF0};
    logic [2:0]  t_sel [6] = '{IMM_SEL_U, IMM_SEL_B, IMM_SEL_NONE, IMM_SEL_NONE,
                               IMM_SEL_U, IMM_SEL_I};
    logic [2:0]  t_fun [6] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2};
    logic        t_ill [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

    initial begin
        int k, guard;
        bit acc;
        rst_n = 1'b0;
        drv(0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        chk("reset_x_valid", x_valid, 0);
        chk("reset_f_ready", f_ready, 1);

        // addi x1,x0,5 into an empty queue
        cyc();
        drv(1, 32'h100, 32'h00500093, 0, 0);
        cyc();
        drv(0, 0, 0, 0, 0);
        chk("addi_valid", x_valid, 1);
        chk("addi_pc", x_pc, 32'h100);
        chk("addi_rd", x_rd, 1);
        chk("addi_imm", x_imm, 5);
        chk("addi_sel", x_imm_sel, IMM_SEL_I);
        chk("addi_fun", x_fun, 0);
        drain();

        // jal x1,8 then sw x2,-4(x1)
        drv(1, 32'h104, 32'h008000EF, 0, 0); cyc();
        drv(1, 32'h108, 32'hFE20AE23, 0, 0); cyc();
        drv(0, 0, 0, 0, 0);
        chk("jal_imm", x_imm, 32'h8);
        chk("jal_sel", x_imm_sel, IMM_SEL_J);
        chk("jal_fun", x_fun, FUNC_ADD);
        drv(0, 0, 0, 1, 0); cyc();
        drv(0, 0, 0, 0, 0);
        chk("sw_pc", x_pc, 32'h108);
        chk("sw_imm", x_imm, 32'hFFFFFFFC);
        chk("sw_sel", x_imm_sel, IMM_SEL_S);
        chk("sw_rs1", x_rs1, 1);
        chk("sw_rs2", x_rs2, 2);
        chk("sw_fun", x_fun, 2);
        drain();

        // fill to DEPTH, then stream with fetch holding rejected words
        for (int i = 0; i < DEPTH; i++) begin
            drv(1, 32'h200 + 4 * i, 32'h00000013 | (i << 7) | (i << 20), 0, 0);
            cyc();
        end
        drv(0, 0, 0, 0, 0);
        chk("full_f_ready", f_ready, 0);
        chk("full_x_valid", x_valid, 1);
        k = 0; guard = 0;
        while (k < 8 && guard < 30) begin
            drv(1, 32'h300 + 4 * k, 32'h00000093 | (k << 15) | ((7 - k) << 20), 1, 0);
            acc = f_ready;
            cyc();
            if (guard == 0) chk("stream_head_pc", x_pc, 32'h204);
            if (acc) k++;
            guard++;
        end
        chk("stream_done", k, 8);
        drain();
        chk("stream_drained", x_valid, 0);

        // kill with a simultaneous push
        drv(1, 32'h400, 32'h00100093, 0, 0); cyc();
        drv(1, 32'h404, 32'h00200093, 0, 0); cyc();
        drv(1, 32'h408, 32'h00300093, 0, 1); cyc();
        drv(0, 0, 0, 0, 0);
        chk("kill_x_valid", x_valid, 0);
        chk("kill_f_ready", f_ready, 1);
        cyc();
        chk("kill_word_gone", x_valid, 0);

        // RF lookahead: bypass on empty, then next entry on pop
        drv(1, 32'h500, 32'h00138113, 0, 0);
        @(negedge clk);
        chk("rf_bypass_rs1", rf_rs1, 7);
        cyc();
        drv(1, 32'h504, 32'h00248193, 0, 0); cyc();
        drv(0, 0, 0, 1, 0);
        @(negedge clk);
        chk("rf_next_rs1", rf_rs1, 9);
        cyc();
        drv(0, 0, 0, 0, 0);
        chk("rf_aligned_x_rs1", x_rs1, 9);
        drain();

        // Immediate table including an unsupported opcode
        for (int i = 0; i < 6; i++) begin
            drv(1, 32'h600 + 4 * i, t_ir[i], 0, 0); cyc();
            drv(0, 0, 0, 0, 0);
            chk("tab_imm", x_imm, t_imm[i]);
            chk("tab_sel", x_imm_sel, t_sel[i]);
            chk("tab_fun", x_fun, t_fun[i]);
`ifdef URV_PREDECODE_ILLEGAL_EN
            chk("tab_illegal", x_illegal, t_ill[i]);
`else
            chk("tab_illegal", x_illegal, 0);
`endif
            drv(0, 0, 0, 1, 0); cyc();
            drv(0, 0, 0, 0, 0);
        end

        // asynchronous reset mid-stream
        drv(1, 32'h700, 32'h00100093, 0, 0); cyc();
        drv(1, 32'h704, 32'h00200093, 0, 0); cyc();
        drv(0, 0, 0, 0, 0);
        chk("pre_reset_valid", x_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_valid", x_valid, 0);
        chk("async_reset_ready", f_ready, 1);
        #3 rst_n = 1'b1;
        cyc();
        chk("post_reset_valid", x_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
